// File: rtl/generic_sram_loader.sv
// generic_sram_loader: packs a valid/ready byte stream into DATA_WIDTH words
// and writes them to consecutive addresses of a memory write port.
module generic_sram_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 10,
  parameter int BYTE_LSB_FIRST = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_base_addr,
  input  logic [ADDRESS_WIDTH-1:0] i_word_count,
  input  logic                     i_byte_valid,
  input  logic [7:0]               i_byte,
  output logic                     o_byte_ready,
  output logic                     o_wr_en,
  output logic [ADDRESS_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0]    o_wr_data,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int BPW = DATA_WIDTH / 8;
  // Byte counter needs at least one bit even when a word is a single byte.
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH-1:0] r_remaining;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [CW-1:0]            r_byte_cnt;
  logic [DATA_WIDTH-1:0]    r_pack;
  logic [DATA_WIDTH-1:0]    r_wr_data;
  logic [DATA_WIDTH-1:0]    w_pack_next;
  logic                     w_accept;
  logic                     w_last_byte;

  assign w_accept    = (r_state == S_COLLECT) && i_byte_valid;
  assign w_last_byte = (r_byte_cnt == CW'(BPW - 1));

  // Pack register with the incoming byte dropped into its lane.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_pack_next = r_pack;
    if (BYTE_LSB_FIRST != 0) begin
      w_pack_next[8*int'(r_byte_cnt) +: 8] = i_byte;
    end else begin
      w_pack_next[DATA_WIDTH-8-8*int'(r_byte_cnt) +: 8] = i_byte;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (!i_rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = (i_word_count != '0) ? S_COLLECT : S_DONE;
        end
      end
      S_COLLECT: begin
        if (i_byte_valid && w_last_byte) begin
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        w_next_state = (r_remaining == ADDRESS_WIDTH'(1)) ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: load capture, byte packing, write register staging, counters.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_byte_cnt  <= '0;
      r_pack      <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr      <= i_base_addr;
            r_remaining <= i_word_count;
            r_byte_cnt  <= '0;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_pack <= w_pack_next;
            if (w_last_byte) begin
              // Stage the finished word so the write port is driven from flops.
              r_byte_cnt <= '0;
              r_wr_addr  <= r_addr;
              r_wr_data  <= w_pack_next;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        S_WRITE: begin
          // Address wraps naturally modulo 2^ADDRESS_WIDTH.
          r_addr      <= r_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_byte_ready = (r_state == S_COLLECT);
  assign o_wr_en      = (r_state == S_WRITE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;

endmodule

// File: tb/tb_generic_sram_loader.sv
// Directed testbench for generic_sram_loader: three instances (LSB-first,
// MSB-first, 4-bit address) share one stimulus stream.
module tb_generic_sram_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] base;
  logic [9:0] count;
  logic       valid;
  logic [7:0] bdata;

  logic        a_ready, a_wr_en, a_busy, a_done;
  logic [9:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        b_ready, b_wr_en, b_busy, b_done;
  logic [9:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        c_ready, c_wr_en, c_busy, c_done;
  logic [3:0]  c_wr_addr;
  logic [31:0] c_wr_data;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  wr_t qc[$];
  int  done_a;
  int  rdy_a;
  int  cyc;
  int  last_hs;
  int  hs3[4];
  int  total;
  int  bad;

  logic [7:0] s1[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] s4[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
  logic [7:0] s6[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  generic_sram_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(10), .BYTE_LSB_FIRST(1)) u_a (
    .i_clk(clk), .i_rstn(rst_n), .i_start(start), .i_base_addr(base), .i_word_count(count),
    .i_byte_valid(valid), .i_byte(bdata), .o_byte_ready(a_ready), .o_wr_en(a_wr_en),
    .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data), .o_busy(a_busy), .o_done(a_done)
  );

  generic_sram_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(10), .BYTE_LSB_FIRST(0)) u_b (
    .i_clk(clk), .i_rstn(rst_n), .i_start(start), .i_base_addr(base), .i_word_count(count),
    .i_byte_valid(valid), .i_byte(bdata), .o_byte_ready(b_ready), .o_wr_en(b_wr_en),
    .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data), .o_busy(b_busy), .o_done(b_done)
  );

  generic_sram_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_LSB_FIRST(1)) u_c (
    .i_clk(clk), .i_rstn(rst_n), .i_start(start), .i_base_addr(base[3:0]), .i_word_count(count[3:0]),
    .i_byte_valid(valid), .i_byte(bdata), .o_byte_ready(c_ready), .o_wr_en(c_wr_en),
    .o_wr_addr(c_wr_addr), .o_wr_data(c_wr_data), .o_busy(c_busy), .o_done(c_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done/ready logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_wr_en) qa.push_back('{32'(a_wr_addr), a_wr_data, cyc});
    if (b_wr_en) qb.push_back('{32'(b_wr_addr), b_wr_data, cyc});
    if (c_wr_en) qc.push_back('{32'(c_wr_addr), c_wr_data, cyc});
    if (a_done) done_a++;
    if (a_ready) rdy_a++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    qa.delete();
    qb.delete();
    qc.delete();
    done_a = 0;
    rdy_a  = 0;
  endtask

  task automatic start_load(input logic [9:0] b, input logic [9:0] n);
    start = 1'b1;
    base  = b;
    count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer a byte and hold it until accepted; valid stays high on return.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n     = 0;
    valid = 1'b1;
    bdata = b;
    while (!a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hs_bound", 32'(n < 20), 32'd1);
    last_hs = cyc;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!a_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(a_done), 32'd1);
    @(negedge clk);
    check("done_pulse_1cyc", 32'(a_done), 32'd0);
    check("busy_after", 32'(a_busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int hs_w0;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    base  = '0;
    count = '0;
    valid = 1'b0;
    bdata = '0;
    clear_logs();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_wr_en", 32'(a_wr_en), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_wr_addr", 32'(a_wr_addr), 32'd0);
    check("rst_wr_data", a_wr_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two words, both byte orders
    clear_logs();
    start_load(10'h010, 10'd2);
    check("t1_busy", 32'(a_busy), 32'd1);
    hs_w0 = 0;
    for (int i = 0; i < 8; i++) begin
      send_byte(s1[i]);
      if (i == 3) hs_w0 = last_hs;
    end
    valid = 1'b0;
    wait_done();
    check("t1_nwr", 32'(qa.size()), 32'd2);
    check("t1_addr0", qa[0].addr, 32'h010);
    check("t1_data0", qa[0].data, 32'h44332211);
    check("t1_addr1", qa[1].addr, 32'h011);
    check("t1_data1", qa[1].data, 32'h88776655);
    check("t1_lat0", 32'(qa[0].cyc), 32'(hs_w0 + 1));
    check("t1_lat1", 32'(qa[1].cyc), 32'(last_hs + 1));
    check("t1_ndone", 32'(done_a), 32'd1);
    check("t2_data0", qb[0].data, 32'h11223344);
    check("t2_data1", qb[1].data, 32'h55667788);

    // Valid stalls between bytes
    clear_logs();
    start_load(10'h030, 10'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(s1[i]);
      hs3[i] = last_hs;
      valid = 1'b0;
      if (i < 3) repeat (2) @(negedge clk);
      if (i == 2) check("t3_no_early_wr", 32'(qa.size()), 32'd0);
    end
    wait_done();
    check("t3_nwr", 32'(qa.size()), 32'd1);
    check("t3_addr", qa[0].addr, 32'h030);
    check("t3_data", qa[0].data, 32'h44332211);
    check("t3_lat", 32'(qa[0].cyc), 32'(hs3[3] + 1));
    check("t3_data_msb", qb[0].data, 32'h11223344);

    // Address wrap on a 4-bit port, start pulse mid-load ignored
    clear_logs();
    start_load(10'h00F, 10'd2);
    send_byte(s4[0]);
    send_byte(s4[1]);
    valid = 1'b0;
    start = 1'b1;
    base  = 10'h005;
    count = 10'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i < 8; i++) send_byte(s4[i]);
    valid = 1'b0;
    wait_done();
    check("t4_nwr_c", 32'(qc.size()), 32'd2);
    check("t4_addr0_c", qc[0].addr, 32'h0F);
    check("t4_addr1_c", qc[1].addr, 32'h00);
    check("t4_data1_c", qc[1].data, 32'h08070605);
    check("t4_nwr_a", 32'(qa.size()), 32'd2);
    check("t4_addr0_a", qa[0].addr, 32'h00F);
    check("t4_addr1_a", qa[1].addr, 32'h010);
    check("t4_data0_a", qa[0].data, 32'h04030201);
    check("t4_ndone", 32'(done_a), 32'd1);

    // Zero-length load
    clear_logs();
    start_load(10'h050, 10'd0);
    check("t5_done", 32'(a_done), 32'd1);
    check("t5_ready", 32'(a_ready), 32'd0);
    check("t5_busy", 32'(a_busy), 32'd1);
    @(negedge clk);
    check("t5_done_drop", 32'(a_done), 32'd0);
    check("t5_busy_drop", 32'(a_busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t5_nwr", 32'(qa.size()), 32'd0);
    check("t5_nready", 32'(rdy_a), 32'd0);
    check("t5_hold_addr", 32'(a_wr_addr), 32'h010);

    // Asynchronous reset mid-word, then a fresh load
    clear_logs();
    start_load(10'h040, 10'd1);
    send_byte(s4[0]);
    send_byte(s4[1]);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(a_ready), 32'd0);
    check("t6_rst_busy", 32'(a_busy), 32'd0);
    check("t6_rst_wr_en", 32'(a_wr_en), 32'd0);
    check("t6_rst_addr", 32'(a_wr_addr), 32'd0);
    check("t6_rst_data", a_wr_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_nwr_partial", 32'(qa.size()), 32'd0);
    start_load(10'h020, 10'd1);
    for (int i = 0; i < 4; i++) send_byte(s6[i]);
    valid = 1'b0;
    wait_done();
    check("t6_nwr", 32'(qa.size()), 32'd1);
    check("t6_addr", qa[0].addr, 32'h020);
    check("t6_data", qa[0].data, 32'hDDCCBBAA);
    check("t6_data_msb", qb[0].data, 32'hAABBCCDD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
